// File: rtl/unidade_controle_pkg.sv
// -----------------------------------------------------------------------------
// unidade_controle_pkg
// Shared definitions for the round-based memory game control unit.
//   estado_t            : FSM state type; each enumerator value is the
//                         4-bit code shown on db_estado.
//   DB_ESTADO_INVALIDO  : code shown on db_estado for any unused encoding.
// -----------------------------------------------------------------------------
package unidade_controle_pkg;

  typedef enum logic [3:0] {
    ST_INICIAL        = 4'h0,
    ST_PREPARACAO     = 4'h1,
    ST_INICIA_RODADA  = 4'h2,
    ST_ESPERA         = 4'h3,
    ST_REGISTRA       = 4'h4,
    ST_COMPARACAO     = 4'h5,
    ST_PROXIMA_JOGADA = 4'h6,
    ST_PROXIMA_RODADA = 4'h7,
    ST_FIM_TIMEOUT    = 4'hC,
    ST_VITORIA        = 4'hD,
    ST_DERROTA        = 4'hE
  } estado_t;

  localparam logic [3:0] DB_ESTADO_INVALIDO = 4'hF;

endpackage

// File: rtl/contador_timeout.sv
// -----------------------------------------------------------------------------
// contador_timeout
// Play timeout counter: TW-bit up-counter with synchronous clear and count
// enable, plus a flag that is high while the count equals TIMEOUT-1.
// Ports:
//   clock   in  system clock (rising edge)
//   reset   in  asynchronous active-high reset, clears the count
//   i_zera  in  synchronous clear (has priority over i_conta)
//   i_conta in  count enable
//   o_fim   out count == TIMEOUT-1
// -----------------------------------------------------------------------------
module contador_timeout #(
  parameter int TIMEOUT = 5000,
  localparam int TW = $clog2(TIMEOUT)
) (
  input  logic clock,
  input  logic reset,
  input  logic i_zera,
  input  logic i_conta,
  output logic o_fim
);

  logic [TW-1:0] r_valor;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valor <= '0;
    end else if (i_zera) begin
      r_valor <= '0;
    end else if (i_conta) begin
      r_valor <= r_valor + TW'(1);
    end
  end

  assign o_fim = (r_valor == TW'(TIMEOUT - 1));

endmodule

// File: rtl/unidade_controle_rodadas.sv
// -----------------------------------------------------------------------------
// unidade_controle_rodadas
// Control unit for the memory game with growing sequences. Round r requires
// the player to repeat the first r+1 stored plays; after N_RODADAS rounds the
// game is won. Drives the datapath (address counter, play register) and shows
// state and round for debug.
//
// Build option: define TIMEOUT_EN to include the per-play timeout. Without it
// the timer is absent, espera waits forever, timeout is 0 and the
// fim_timeout code is treated as an invalid state.
//
// Ports:
//   clock      in  system clock (rising edge)
//   reset      in  asynchronous active-high reset -> inicial, counters cleared
//   iniciar    in  start/restart request (level)
//   jogada     in  play-detected pulse
//   igual      in  registered play matches memory at current address
//   fimE       in  address counter reached the current round index
//   zeraE      out clear address counter
//   contaE     out increment address counter
//   zeraR      out clear play register
//   registraR  out load play register
//   pronto     out game finished
//   acertou    out game won
//   errou      out game lost (wrong play or timeout)
//   timeout    out game lost by timeout
//   rodada     out current round, 0-based
//   db_estado  out 4-bit state code
// -----------------------------------------------------------------------------
module unidade_controle_rodadas
  import unidade_controle_pkg::*;
#(
  parameter int N_RODADAS = 16,
  parameter int TIMEOUT   = 5000,
  localparam int RW = $clog2(N_RODADAS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          jogada,
  input  logic          igual,
  input  logic          fimE,
  output logic          zeraE,
  output logic          contaE,
  output logic          zeraR,
  output logic          registraR,
  output logic          pronto,
  output logic          acertou,
  output logic          errou,
  output logic          timeout,
  output logic [RW-1:0] rodada,
  output logic [3:0]    db_estado
);

  estado_t       r_estado;
  estado_t       w_proximo;
  logic [RW-1:0] r_rodada;
  logic          w_em_espera;
  logic          w_expirou;
  logic          w_ultima_rodada;

  assign w_em_espera     = (r_estado == ST_ESPERA);
  assign w_ultima_rodada = (r_rodada == RW'(N_RODADAS - 1));

`ifdef TIMEOUT_EN
  logic w_timer_fim;

  // Timer runs only while waiting for a play; any other state clears it, so
  // every entry into espera starts a fresh TIMEOUT-cycle window.
  contador_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_contador_timeout (
    .clock   (clock),
    .reset   (reset),
    .i_zera  (~w_em_espera),
    .i_conta (w_em_espera),
    .o_fim   (w_timer_fim)
  );

  assign w_expirou = w_timer_fim & w_em_espera;
`else
  assign w_expirou = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= ST_INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // Round counter. It is cleared on every edge that lands in preparacao, so a
  // restart from a terminal state already shows round 0 during preparacao,
  // while terminal states keep the reached round visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rodada <= '0;
    end else if (w_proximo == ST_PREPARACAO) begin
      r_rodada <= '0;
    end else if (r_estado == ST_PROXIMA_RODADA) begin
      r_rodada <= r_rodada + RW'(1);
    end
  end

  // Next-state and Moore outputs
  always_comb begin
    w_proximo = ST_INICIAL;
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    db_estado = r_estado;

    case (r_estado)
      ST_INICIAL: begin
        zeraE     = 1'b1;
        zeraR     = 1'b1;
        w_proximo = iniciar ? ST_PREPARACAO : ST_INICIAL;
      end
      ST_PREPARACAO: begin
        zeraE     = 1'b1;
        zeraR     = 1'b1;
        w_proximo = ST_INICIA_RODADA;
      end
      ST_INICIA_RODADA: begin
        zeraE     = 1'b1;
        w_proximo = ST_ESPERA;
      end
      ST_ESPERA: begin
        // A play in the expiry cycle still counts.
        if (jogada) begin
          w_proximo = ST_REGISTRA;
        end else if (w_expirou) begin
          w_proximo = ST_FIM_TIMEOUT;
        end else begin
          w_proximo = ST_ESPERA;
        end
      end
      ST_REGISTRA: begin
        registraR = 1'b1;
        w_proximo = ST_COMPARACAO;
      end
      ST_COMPARACAO: begin
        if (!igual) begin
          w_proximo = ST_DERROTA;
        end else if (fimE && w_ultima_rodada) begin
          w_proximo = ST_VITORIA;
        end else if (fimE) begin
          w_proximo = ST_PROXIMA_RODADA;
        end else begin
          w_proximo = ST_PROXIMA_JOGADA;
        end
      end
      ST_PROXIMA_JOGADA: begin
        contaE    = 1'b1;
        w_proximo = ST_ESPERA;
      end
      ST_PROXIMA_RODADA: begin
        w_proximo = ST_INICIA_RODADA;
      end
`ifdef TIMEOUT_EN
      ST_FIM_TIMEOUT: begin
        pronto    = 1'b1;
        errou     = 1'b1;
        timeout   = 1'b1;
        w_proximo = iniciar ? ST_PREPARACAO : ST_FIM_TIMEOUT;
      end
`endif
      ST_VITORIA: begin
        pronto    = 1'b1;
        acertou   = 1'b1;
        w_proximo = iniciar ? ST_PREPARACAO : ST_VITORIA;
      end
      ST_DERROTA: begin
        pronto    = 1'b1;
        errou     = 1'b1;
        w_proximo = iniciar ? ST_PREPARACAO : ST_DERROTA;
      end
      default: begin
        db_estado = DB_ESTADO_INVALIDO;
        w_proximo = ST_INICIAL;
      end
    endcase
  end

  assign rodada = r_rodada;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// -----------------------------------------------------------------------------
// Testbench for unidade_controle_rodadas with N_RODADAS=4, TIMEOUT=8.
// The bench acts as the player and datapath: it supplies jogada/igual/fimE
// and predicts each outcome from the game rules (which play of which round,
// right or wrong) rather than from the controller's structure.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_unidade_controle_rodadas;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int RW = $clog2(N);

  logic          clock = 1'b0;
  logic          reset;
  logic          iniciar, jogada, igual, fimE;
  logic          zeraE, contaE, zeraR, registraR;
  logic          pronto, acertou, errou, timeout;
  logic [RW-1:0] rodada;
  logic [3:0]    db_estado;

  int n_tests = 0;
  int n_fail  = 0;

  unidade_controle_rodadas #(
    .N_RODADAS (N),
    .TIMEOUT   (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .jogada    (jogada),
    .igual     (igual),
    .fimE      (fimE),
    .zeraE     (zeraE),
    .contaE    (contaE),
    .zeraR     (zeraR),
    .registraR (registraR),
    .pronto    (pronto),
    .acertou   (acertou),
    .errou     (errou),
    .timeout   (timeout),
    .rodada    (rodada),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  // Advance one cycle; sampling happens 1ns after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Game outcome rule for play j of round r.
  function automatic logic [3:0] outcome(input int r, input int j, input bit ok);
    if (!ok)                   return 4'hE;
    if (j == r && r == N - 1)  return 4'hD;
    if (j == r)                return 4'h7;
    return 4'h6;
  endfunction

  // From inicial or a terminal state: iniciar, expect preparacao with round 0,
  // then inicia_rodada, then espera on the third cycle.
  task automatic start_game();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    n_tests++;
    if (db_estado !== 4'h1 || rodada !== '0 || zeraE !== 1'b1 || zeraR !== 1'b1) begin
      n_fail++;
      $display("FAIL start_prep: estado=%h rodada=%0d zeraE=%b zeraR=%b, need 1/0/1/1",
               db_estado, rodada, zeraE, zeraR);
    end
    tick();
    n_tests++;
    if (db_estado !== 4'h2 || zeraE !== 1'b1) begin
      n_fail++;
      $display("FAIL start_inicia: estado=%h zeraE=%b, need 2/1", db_estado, zeraE);
    end
    tick();
    n_tests++;
    if (db_estado !== 4'h3) begin
      n_fail++;
      $display("FAIL start_espera: estado=%h, need 3", db_estado);
    end
  endtask

  // One play in espera after `gap` idle cycles; follows it to the next espera
  // or to a terminal state.
  task automatic do_play(input int r, input int j, input bit ok, input int gap);
    logic [3:0] exp;
    repeat (gap) tick();
    n_tests++;
    if (db_estado !== 4'h3 || rodada !== RW'(r)) begin
      n_fail++;
      $display("FAIL play_espera r%0d j%0d: estado=%h rodada=%0d, need 3/%0d",
               r, j, db_estado, rodada, r);
    end
    jogada = 1'b1;
    igual  = ok;
    fimE   = (j == r);
    tick();
    jogada = 1'b0;
    n_tests++;
    if (db_estado !== 4'h4 || registraR !== 1'b1) begin
      n_fail++;
      $display("FAIL play_registra r%0d j%0d: estado=%h registraR=%b, need 4/1",
               r, j, db_estado, registraR);
    end
    tick();
    n_tests++;
    if (db_estado !== 4'h5) begin
      n_fail++;
      $display("FAIL play_compara r%0d j%0d: estado=%h, need 5", r, j, db_estado);
    end
    tick();
    exp = outcome(r, j, ok);
    n_tests++;
    if (db_estado !== exp || rodada !== RW'(r)) begin
      n_fail++;
      $display("FAIL play_outcome r%0d j%0d: estado=%h rodada=%0d, need %h/%0d",
               r, j, db_estado, rodada, exp, r);
    end
    $display("[TB] play round=%0d idx=%0d ok=%0d gap=%0d -> estado=%h", r, j, ok, gap, db_estado);
    if (exp == 4'h6) begin
      n_tests++;
      if (contaE !== 1'b1) begin
        n_fail++;
        $display("FAIL play_contaE r%0d j%0d: contaE=%b, need 1", r, j, contaE);
      end
      tick();
    end else if (exp == 4'h7) begin
      tick();
      n_tests++;
      if (db_estado !== 4'h2 || rodada !== RW'(r + 1)) begin
        n_fail++;
        $display("FAIL next_round r%0d: estado=%h rodada=%0d, need 2/%0d",
                 r, db_estado, rodada, r + 1);
      end
      tick();
    end
    igual = 1'b0;
    fimE  = 1'b0;
  endtask

  // Plays one full round; a negative fail_j means every play is correct.
  task automatic play_round(input int r, input int fail_j, input int max_gap, output bit lost);
    lost = 1'b0;
    for (int j = 0; j <= r; j++) begin
      do_play(r, j, j != fail_j, $urandom_range(0, max_gap));
      if (j == fail_j) begin
        lost = 1'b1;
        break;
      end
    end
  endtask

  // Full game; fail_r >= N means a win.
  task automatic play_game(input int fail_r, input int fail_j, input int max_gap);
    bit lost;
    start_game();
    for (int r = 0; r < N; r++) begin
      play_round(r, (r == fail_r) ? fail_j : -1, max_gap, lost);
      if (lost) break;
    end
    n_tests++;
    if (fail_r >= N) begin
      if (acertou !== 1'b1 || pronto !== 1'b1 || errou !== 1'b0 || rodada !== RW'(N - 1)
          || db_estado !== 4'hD) begin
        n_fail++;
        $display("FAIL game_win: acertou=%b pronto=%b errou=%b rodada=%0d estado=%h, need 1/1/0/%0d/D",
                 acertou, pronto, errou, rodada, db_estado, N - 1);
      end
    end else begin
      if (errou !== 1'b1 || pronto !== 1'b1 || acertou !== 1'b0 || timeout !== 1'b0
          || rodada !== RW'(fail_r) || db_estado !== 4'hE) begin
        n_fail++;
        $display("FAIL game_loss: errou=%b pronto=%b acertou=%b timeout=%b rodada=%0d estado=%h, need 1/1/0/0/%0d/E",
                 errou, pronto, acertou, timeout, rodada, db_estado, fail_r);
      end
    end
    $display("[TB] game fail_round=%0d fail_idx=%0d -> estado=%h rodada=%0d", fail_r, fail_j, db_estado, rodada);
  endtask

  task automatic test_reset();
    bit lost;
    n_tests++;
    if (db_estado !== 4'h0 || zeraE !== 1'b1 || zeraR !== 1'b1 || rodada !== '0 ||
        contaE !== 1'b0 || registraR !== 1'b0 || pronto !== 1'b0 || acertou !== 1'b0 ||
        errou !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: estado=%h zeraE=%b zeraR=%b rodada=%0d others=%b%b%b%b%b%b",
               db_estado, zeraE, zeraR, rodada, contaE, registraR, pronto, acertou, errou, timeout);
    end
    // Idle in inicial without iniciar
    tick();
    tick();
    n_tests++;
    if (db_estado !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_hold: estado=%h, need 0", db_estado);
    end
    // Reach espera of round 2, then pulse reset between edges
    start_game();
    play_round(0, -1, 3, lost);
    play_round(1, -1, 3, lost);
    tick();
    n_tests++;
    if (db_estado !== 4'h3 || rodada !== RW'(2)) begin
      n_fail++;
      $display("FAIL reset_setup: estado=%h rodada=%0d, need 3/2", db_estado, rodada);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (db_estado !== 4'h0 || rodada !== '0 || zeraE !== 1'b1 || pronto !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: estado=%h rodada=%0d zeraE=%b pronto=%b, need 0/0/1/0",
               db_estado, rodada, zeraE, pronto);
    end
    #1 reset = 1'b0;
    tick();
    n_tests++;
    if (db_estado !== 4'h0 || rodada !== '0 || zeraE !== 1'b1 || pronto !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: estado=%h rodada=%0d zeraE=%b pronto=%b, need 0/0/1/0",
               db_estado, rodada, zeraE, pronto);
    end
    $display("[TB] reset mid-espera round 2 -> estado=%h rodada=%0d", db_estado, rodada);
  endtask

  task automatic test_win();
    play_game(N, 0, 2);
    // Terminal state holds without iniciar
    tick();
    tick();
    n_tests++;
    if (db_estado !== 4'hD || rodada !== RW'(N - 1)) begin
      n_fail++;
      $display("FAIL win_hold: estado=%h rodada=%0d, need D/%0d", db_estado, rodada, N - 1);
    end
  endtask

  task automatic test_wrong();
    play_game(1, 1, 2);
  endtask

  task automatic test_restart();
    n_tests++;
    if (db_estado !== 4'hE || rodada !== RW'(1)) begin
      n_fail++;
      $display("FAIL restart_pre: estado=%h rodada=%0d, need E/1", db_estado, rodada);
    end
    start_game();
    $display("[TB] restart from derrota -> estado=%h rodada=%0d", db_estado, rodada);
  endtask

`ifdef TIMEOUT_EN
  task automatic test_timeout();
    start_game();
    // One cycle already spent in espera; TO-1 more keep it there.
    for (int k = 1; k < TO; k++) begin
      n_tests++;
      if (db_estado !== 4'h3 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait cyc%0d: estado=%h timeout=%b, need 3/0", k, db_estado, timeout);
      end
      tick();
    end
    n_tests++;
    if (db_estado !== 4'h3) begin
      n_fail++;
      $display("FAIL timeout_last: estado=%h, need 3", db_estado);
    end
    tick();
    n_tests++;
    if (db_estado !== 4'hC || timeout !== 1'b1 || errou !== 1'b1 || pronto !== 1'b1 ||
        acertou !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fire: estado=%h timeout=%b errou=%b pronto=%b acertou=%b, need C/1/1/1/0",
               db_estado, timeout, errou, pronto, acertou);
    end
    $display("[TB] idle %0d cycles in espera -> estado=%h", TO, db_estado);
    // Again, but a play arrives in the expiry cycle
    start_game();
    repeat (TO - 1) tick();
    jogada = 1'b1;
    igual  = 1'b1;
    fimE   = 1'b1;
    tick();
    jogada = 1'b0;
    n_tests++;
    if (db_estado !== 4'h4 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_race: estado=%h timeout=%b, need 4/0", db_estado, timeout);
    end
    $display("[TB] play on expiry cycle -> estado=%h", db_estado);
    tick();
    tick();
    n_tests++;
    if (db_estado !== 4'h7) begin
      n_fail++;
      $display("FAIL timeout_race_outcome: estado=%h, need 7", db_estado);
    end
    igual = 1'b0;
    fimE  = 1'b0;
    tick();
    tick();
    do_play(1, 0, 1'b0, 0);
  endtask
`else
  task automatic test_no_timeout();
    start_game();
    for (int k = 0; k < 100; k++) begin
      tick();
      n_tests++;
      if (db_estado !== 4'h3 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL no_timeout cyc%0d: estado=%h timeout=%b, need 3/0", k, db_estado, timeout);
      end
    end
    $display("[TB] idle 100 cycles in espera -> estado=%h timeout=%b", db_estado, timeout);
    do_play(0, 0, 1'b0, 0);
  endtask
`endif

  task automatic test_random_games();
    int fr, fj;
    for (int g = 0; g < 8; g++) begin
      fr = $urandom_range(0, N);
      fj = (fr < N) ? $urandom_range(0, fr) : 0;
      play_game(fr, fj, 5);
    end
  endtask

  initial begin
    reset   = 1'b1;
    iniciar = 1'b0;
    jogada  = 1'b0;
    igual   = 1'b0;
    fimE    = 1'b0;
    #12;
    test_reset_values_wrapper();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic test_reset_values_wrapper();
    test_reset_values_under_reset();
    reset = 1'b0;
    tick();
    test_reset();
    test_win();
    test_wrong();
    test_restart();
    do_play(0, 0, 1'b0, 1);
`ifdef TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random_games();
  endtask

  // Outputs while reset is still asserted and the clock is running.
  task automatic test_reset_values_under_reset();
    n_tests++;
    if (db_estado !== 4'h0 || zeraE !== 1'b1 || zeraR !== 1'b1 || rodada !== '0 || pronto !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_asserted: estado=%h zeraE=%b zeraR=%b rodada=%0d pronto=%b, need 0/1/1/0/0",
               db_estado, zeraE, zeraR, rodada, pronto);
    end
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unidade_controle_rodadas.md
# unidade_controle_rodadas

Parametrised control unit for the memory game with growing sequences: round r requires the player to repeat the first r+1 stored plays before the sequence grows. It has an internal round counter and an optional per-play timeout. It drives the game's datapath (address counter, play register, comparator) and exposes state and round for debug displays.

## Interface
- N_RODADAS, default 16: number of rounds to win (≥2); RW = $clog2(N_RODADAS).
- TIMEOUT, default 5000: clock cycles allowed in espera before a timeout (≥2); TW = $clog2(TIMEOUT).
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces state inicial and clears all internal counters.
- iniciar  in  1  start/restart request, level-sampled.
- jogada  in  1  play-detected pulse from the datapath edge detector.
- igual  in  1  comparator result: registered play equals memory at the current address.
- fimE  in  1  address counter equals rodada (last play of the current round).
- zeraE  out  1  clear address counter.
- contaE  out  1  increment address counter.
- zeraR  out  1  clear play register.
- registraR  out  1  load play register.
- pronto  out  1  game finished (vitoria, derrota or fim_timeout).
- acertou  out  1  game won.
- errou  out  1  game lost by wrong play or timeout.
- timeout  out  1  game lost by timeout.
- rodada  out  RW  current round index, 0-based.
- db_estado  out  4  state code.

## Operation
- State codes: inicial 0, preparacao 1, inicia_rodada 2, espera 3, registra 4, comparacao 5, proxima_jogada 6, proxima_rodada 7, fim_timeout C, vitoria D, derrota E; any other code shows F and goes to inicial.
- Transitions:
  - inicial → preparacao if iniciar.
  - preparacao → inicia_rodada.
  - inicia_rodada → espera.
  - espera → registra if jogada, else → fim_timeout if the timer expires, else stay in espera.
  - registra → comparacao.
  - comparacao has four exits:
    - ~igual → derrota.
    - igual & fimE & rodada==N_RODADAS-1 → vitoria.
    - igual & fimE → proxima_rodada.
    - otherwise → proxima_jogada.
  - proxima_jogada → espera.
  - proxima_rodada → inicia_rodada.
  - vitoria, derrota and fim_timeout → preparacao if iniciar, else hold.
- Moore outputs:
  - zeraE=1 in inicial, preparacao and inicia_rodada.
  - zeraR=1 in inicial and preparacao.
  - registraR=1 in registra.
  - contaE=1 in proxima_jogada.
  - pronto=1 in vitoria, derrota and fim_timeout.
  - acertou=1 in vitoria.
  - errou=1 in derrota and fim_timeout.
  - timeout=1 in fim_timeout.
- Round counter:
  - Cleared to 0 in preparacao; +1 on the clock edge leaving proxima_rodada.
  - Never wraps: vitoria is reached before the counter exceeds N_RODADAS-1.
  - Holds its value in terminal states, so the reached round stays visible.
- Timer:
  - Cleared whenever the state is not espera; increments by 1 each cycle in espera.
  - Expires when it equals TIMEOUT-1 while in espera.
- jogada and expiry in the same cycle: jogada wins (→ registra).
- jogada outside espera is ignored.
- Reset mid-game: returns to inicial immediately, asynchronously; rodada=0, timer=0.

## Timing
- Reset values: db_estado=0, zeraE=1, zeraR=1, rodada=0, all other outputs 0.
- iniciar to first espera: 3 cycles (preparacao, inicia_rodada, espera).
- jogada to comparison decision: registra then comparacao, 2 cycles; outcome state follows on the 3rd edge.
- Correct non-final play: comparacao → proxima_jogada → espera. Next play accepted 2 cycles after comparacao.
- Timeout: fim_timeout is entered exactly TIMEOUT cycles after entering espera with no jogada.

## Configuration
- TIMEOUT_EN defined: timer present as above; fim_timeout reachable.
- TIMEOUT_EN undefined:
  - Timer logic is removed; espera waits indefinitely.
  - timeout is tied to 0; fim_timeout is unreachable and decodes as default.
  - The TIMEOUT parameter is ignored.

## Structure
- Package unidade_controle_pkg: 4-bit state code constants and the db_estado default F.
- One sub-module, contador_timeout (TW-bit counter with clear, enable and expiry flag), instantiated only under TIMEOUT_EN.
- The round counter stays inline.

## Test plan
Bench parameters: N_RODADAS=4, TIMEOUT=8.

- reset pulse mid-espera, round 2 → next cycle db_estado=0, rodada=0, zeraE=1, pronto=0.
- Win: iniciar, then correct plays 1+2+3+4 with fimE asserted on each round's last play → acertou=1, pronto=1, rodada=3, db_estado=D.
- Wrong play: igual=0 on the 2nd play of round 1 → db_estado=E, errou=1, timeout=0, rodada=1.
- Timeout (TIMEOUT_EN): no jogada for 8 cycles in espera → fim_timeout on cycle 8, timeout=1, errou=1; with jogada on cycle 8 instead → registra.
- No TIMEOUT_EN: 100 idle cycles in espera → state stays 3, timeout=0.
- Restart from derrota with iniciar → preparacao, rodada cleared to 0, first espera 3 cycles later.
